// File: rtl/rotor_stage.sv
// rotor_stage: position register and the two rotations that wrap one Enigma rotor's
// fixed wiring filter, with stepping, turnover carry and a registered letter output.
module rotor_stage #(
    parameter logic [4:0] NOTCH = 5'd21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [4:0]  ld_pos,
    input  logic        step,
    input  logic        in_valid,
    input  logic [25:0] fwd_in,
    input  logic [25:0] inv_in,
    output logic [25:0] to_filt,
    output logic [25:0] to_filt_inv,
    input  logic [25:0] from_filt,
    input  logic [25:0] from_filt_inv,
    output logic [25:0] fwd_out,
    output logic [25:0] inv_out,
    output logic        out_valid,
    output logic [4:0]  pos,
    output logic        at_notch,
    output logic        carry
);

    localparam logic [4:0] LAST_POS = 5'd25;

    // Entering the filter: out[j] = v[(j - p) mod 26].
    function automatic logic [25:0] rot_in(input logic [25:0] v, input logic [4:0] p);
        logic [25:0] r;
        logic [5:0]  idx;
        logic [5:0]  sel;
        r = 26'd0;
        for (int j = 0; j < 26; j++) begin
            idx  = 6'(j) + 6'd26 - {1'b0, p};
            sel  = (idx >= 6'd26) ? (idx - 6'd26) : idx;
            r[j] = v[sel[4:0]];
        end
        return r;
    endfunction

    // Leaving the filter: out[k] = v[(k + p) mod 26].
    function automatic logic [25:0] rot_out(input logic [25:0] v, input logic [4:0] p);
        logic [25:0] r;
        logic [5:0]  idx;
        logic [5:0]  sel;
        r = 26'd0;
        for (int k = 0; k < 26; k++) begin
            idx  = 6'(k) + {1'b0, p};
            sel  = (idx >= 6'd26) ? (idx - 6'd26) : idx;
            r[k] = v[sel[4:0]];
        end
        return r;
    endfunction

    logic [4:0]  pos_r;
    logic        carry_r;
    logic        out_valid_r;
    logic [25:0] fwd_out_r;
    logic [25:0] inv_out_r;
    logic [25:0] fwd_next_s;
    logic [25:0] inv_next_s;

    // Combinational rotations around the filter using the current position.
    always_comb begin
        to_filt     = rot_in(fwd_in, pos_r);
        to_filt_inv = rot_in(inv_in, pos_r);
        fwd_next_s  = rot_out(from_filt, pos_r);
        inv_next_s  = rot_out(from_filt_inv, pos_r);
    end

    // Position, carry and registered translation results.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_r       <= 5'd0;
            carry_r     <= 1'b0;
            out_valid_r <= 1'b0;
            fwd_out_r   <= 26'd0;
            inv_out_r   <= 26'd0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                fwd_out_r <= fwd_next_s;
                inv_out_r <= inv_next_s;
            end else begin
                fwd_out_r <= fwd_out_r;
                inv_out_r <= inv_out_r;
            end
            // An out-of-range load still blocks a same-cycle step.
            if (ld) begin
                carry_r <= 1'b0;
                if (ld_pos <= LAST_POS) begin
                    pos_r <= ld_pos;
                end else begin
                    pos_r <= pos_r;
                end
            end else if (step) begin
                carry_r <= (pos_r == NOTCH);
                pos_r   <= (pos_r == LAST_POS) ? 5'd0 : (pos_r + 5'd1);
            end else begin
                carry_r <= 1'b0;
                pos_r   <= pos_r;
            end
        end
    end

    assign pos       = pos_r;
    assign carry     = carry_r;
    assign out_valid = out_valid_r;
    assign fwd_out   = fwd_out_r;
    assign inv_out   = inv_out_r;
    assign at_notch  = (pos_r == NOTCH);

endmodule

// File: tb/tb_rotor_stage.sv
// Bench for rotor_stage with a Rotor III wiring filter: directed vector table,
// hand-written stepping/reset sequences, and random traffic against a letter-level model.
module tb_rotor_stage;

    logic        clk = 1'b0;
    logic        rst, ld, step, in_valid;
    logic [4:0]  ld_pos;
    logic [25:0] fwd_in, inv_in, to_filt, to_filt_inv, from_filt, from_filt_inv;
    logic [25:0] fwd_out, inv_out;
    logic        out_valid, at_notch, carry;
    logic [4:0]  pos;

    int pass_cnt = 0;
    int total_cnt = 0;
    int wmap[26];
    int winv[26];

    always #5 clk = ~clk;

    rotor_stage #(.NOTCH(5'd21)) dut (
        .clk(clk), .rst(rst), .ld(ld), .ld_pos(ld_pos), .step(step),
        .in_valid(in_valid), .fwd_in(fwd_in), .inv_in(inv_in),
        .to_filt(to_filt), .to_filt_inv(to_filt_inv),
        .from_filt(from_filt), .from_filt_inv(from_filt_inv),
        .fwd_out(fwd_out), .inv_out(inv_out), .out_valid(out_valid),
        .pos(pos), .at_notch(at_notch), .carry(carry)
    );

    // Fixed Rotor III wiring filter (environment, not the reference model).
    always_comb begin
        from_filt     = 26'd0;
        from_filt_inv = 26'd0;
        for (int i = 0; i < 26; i++) begin
            if (to_filt[i])     from_filt[wmap[i]]     = 1'b1;
            if (to_filt_inv[i]) from_filt_inv[winv[i]] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Letter-level model: each set input letter l at position p maps to
    // (wiring[(l + p) mod 26] - p) mod 26.
    function automatic logic [25:0] model_path(input logic [25:0] v, input int p, input bit inv);
        logic [25:0] r;
        int w;
        r = 26'd0;
        for (int l = 0; l < 26; l++) begin
            if (v[l]) begin
                w = inv ? winv[(l + p) % 26] : wmap[(l + p) % 26];
                r[(w - p + 26) % 26] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [25:0] model_tofilt(input logic [25:0] v, input int p);
        logic [25:0] r;
        r = 26'd0;
        for (int l = 0; l < 26; l++)
            if (v[l]) r[(l + p) % 26] = 1'b1;
        return r;
    endfunction

    function automatic logic [25:0] oh(input int l);
        logic [25:0] one;
        one = 26'd1;
        return one << l;
    endfunction

    typedef struct {
        logic ld; logic [4:0] ld_pos; logic step; logic iv;
        int fwd_l; int inv_l; int exp_tf;
        int exp_pos; logic exp_carry; logic exp_notch; logic exp_valid;
        int exp_fwd; int exp_inv;
    } vec_t;

    function automatic vec_t mk(input logic l, input logic [4:0] lp, input logic s, input logic iv,
                                input int fl, input int il, input int tf, input int ep,
                                input logic ec, input logic en, input logic ev,
                                input int ef, input int ei);
        vec_t v;
        v.ld = l; v.ld_pos = lp; v.step = s; v.iv = iv; v.fwd_l = fl; v.inv_l = il;
        v.exp_tf = tf; v.exp_pos = ep; v.exp_carry = ec; v.exp_notch = en;
        v.exp_valid = ev; v.exp_fwd = ef; v.exp_inv = ei;
        return v;
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; ld = 1'b0; ld_pos = 5'd0; step = 1'b0; in_valid = 1'b0;
        fwd_in = 26'd0; inv_in = 26'd0;
    endtask

    vec_t vecs[15];

    initial begin
        string wiring;
        int carries, m_pos;
        logic m_carry, m_valid;
        logic [25:0] m_fwd, m_inv;

        wiring = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
        for (int i = 0; i < 26; i++) begin
            wmap[i] = int'(wiring[i]) - 65;
            winv[wmap[i]] = i;
        end

        // Directed rows: inputs for one cycle, expected outputs after that edge.
        vecs[0]  = mk(1'b0, 5'd0,  1'b0, 1'b1, 0, 1, 0,  0,  1'b0, 1'b0, 1'b1, 1, 0);
        vecs[1]  = mk(1'b1, 5'd1,  1'b0, 1'b0, -1, -1, -1, 1, 1'b0, 1'b0, 1'b0, 1, 0);
        vecs[2]  = mk(1'b0, 5'd0,  1'b0, 1'b1, 0, 0, 1,  1,  1'b0, 1'b0, 1'b1, 2, 25);
        vecs[3]  = mk(1'b1, 5'd21, 1'b0, 1'b0, -1, -1, -1, 21, 1'b0, 1'b1, 1'b0, 2, 25);
        vecs[4]  = mk(1'b0, 5'd0,  1'b1, 1'b0, -1, -1, -1, 22, 1'b1, 1'b0, 1'b0, -1, -1);
        vecs[5]  = mk(1'b0, 5'd0,  1'b0, 1'b0, -1, -1, -1, 22, 1'b0, 1'b0, 1'b0, -1, -1);
        vecs[6]  = mk(1'b1, 5'd25, 1'b0, 1'b0, -1, -1, -1, 25, 1'b0, 1'b0, 1'b0, -1, -1);
        vecs[7]  = mk(1'b0, 5'd0,  1'b1, 1'b0, -1, -1, -1, 0,  1'b0, 1'b0, 1'b0, -1, -1);
        vecs[8]  = mk(1'b1, 5'd5,  1'b1, 1'b0, -1, -1, -1, 5,  1'b0, 1'b0, 1'b0, -1, -1);
        vecs[9]  = mk(1'b1, 5'd3,  1'b0, 1'b0, -1, -1, -1, 3,  1'b0, 1'b0, 1'b0, -1, -1);
        vecs[10] = mk(1'b1, 5'd30, 1'b1, 1'b0, -1, -1, -1, 3,  1'b0, 1'b0, 1'b0, -1, -1);
        vecs[11] = mk(1'b1, 5'd0,  1'b0, 1'b0, -1, -1, -1, 0,  1'b0, 1'b0, 1'b0, -1, -1);
        vecs[12] = mk(1'b0, 5'd0,  1'b1, 1'b1, 0, 2, 0,  1,  1'b0, 1'b0, 1'b1, 1, 6);
        vecs[13] = mk(1'b1, 5'd21, 1'b0, 1'b0, -1, -1, -1, 21, 1'b0, 1'b1, 1'b0, 1, 6);
        vecs[14] = mk(1'b1, 5'd21, 1'b1, 1'b0, -1, -1, -1, 21, 1'b0, 1'b1, 1'b0, 1, 6);

        idle_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("reset_pos", {21'd0, pos}, 26'd0);
        check("reset_fwd", fwd_out, 26'd0);
        check("reset_inv", inv_out, 26'd0);
        check("reset_valid", {25'd0, out_valid}, 26'd0);
        check("reset_carry", {25'd0, carry}, 26'd0);
        check("reset_notch", {25'd0, at_notch}, 26'd0);

        for (int r = 0; r < 15; r++) begin
            ld = vecs[r].ld; ld_pos = vecs[r].ld_pos; step = vecs[r].step;
            in_valid = vecs[r].iv;
            fwd_in = (vecs[r].fwd_l >= 0) ? oh(vecs[r].fwd_l) : 26'd0;
            inv_in = (vecs[r].inv_l >= 0) ? oh(vecs[r].inv_l) : 26'd0;
            #1;
            if (vecs[r].exp_tf >= 0) check($sformatf("row%0d_to_filt", r), to_filt, oh(vecs[r].exp_tf));
            @(posedge clk); #1;
            check($sformatf("row%0d_pos", r), {21'd0, pos}, 26'(vecs[r].exp_pos));
            check($sformatf("row%0d_carry", r), {25'd0, carry}, {25'd0, vecs[r].exp_carry});
            check($sformatf("row%0d_notch", r), {25'd0, at_notch}, {25'd0, vecs[r].exp_notch});
            check($sformatf("row%0d_valid", r), {25'd0, out_valid}, {25'd0, vecs[r].exp_valid});
            if (vecs[r].exp_fwd >= 0) check($sformatf("row%0d_fwd", r), fwd_out, oh(vecs[r].exp_fwd));
            if (vecs[r].exp_inv >= 0) check($sformatf("row%0d_inv", r), inv_out, oh(vecs[r].exp_inv));
            idle_inputs();
        end

        // Full revolution from 0: exactly one isolated carry, seen with POS = 22.
        ld = 1'b1; ld_pos = 5'd0;
        @(posedge clk); #1;
        idle_inputs();
        carries = 0;
        step = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(posedge clk); #1;
            if (carry) begin
                carries++;
                check("carry_at_pos22", {21'd0, pos}, 26'd22);
            end
        end
        step = 1'b0;
        check("rev_pos_back_to_0", {21'd0, pos}, 26'd0);
        check("rev_carry_count", 26'(carries), 26'd1);
        @(posedge clk); #1;
        check("rev_carry_cleared", {25'd0, carry}, 26'd0);

        // Reset during a translation discards it.
        ld = 1'b1; ld_pos = 5'd21;
        @(posedge clk); #1;
        idle_inputs();
        step = 1'b1; in_valid = 1'b1; fwd_in = oh(4); inv_in = oh(9); rst = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        check("rst_valid", {25'd0, out_valid}, 26'd0);
        check("rst_pos", {21'd0, pos}, 26'd0);
        check("rst_fwd", fwd_out, 26'd0);
        check("rst_inv", inv_out, 26'd0);
        check("rst_carry", {25'd0, carry}, 26'd0);

        // Random traffic against the letter-level model (state matches reset here).
        m_pos = 0; m_carry = 1'b0; m_valid = 1'b0; m_fwd = 26'd0; m_inv = 26'd0;
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 49) == 0);
            ld       = ($urandom_range(0, 5) == 0);
            ld_pos   = 5'($urandom_range(0, 31));
            step     = ($urandom_range(0, 1) == 1);
            in_valid = ($urandom_range(0, 2) != 0);
            fwd_in   = ($urandom_range(0, 3) == 0) ? 26'($urandom) : oh($urandom_range(0, 25));
            inv_in   = ($urandom_range(0, 3) == 0) ? 26'($urandom) : oh($urandom_range(0, 25));
            #1;
            check("rnd_to_filt", to_filt, model_tofilt(fwd_in, m_pos));
            check("rnd_to_filt_inv", to_filt_inv, model_tofilt(inv_in, m_pos));
            check("rnd_notch", {25'd0, at_notch}, {25'd0, (m_pos == 21)});
            if (rst) begin
                m_pos = 0; m_carry = 1'b0; m_valid = 1'b0; m_fwd = 26'd0; m_inv = 26'd0;
            end else begin
                m_valid = in_valid;
                if (in_valid) begin
                    m_fwd = model_path(fwd_in, m_pos, 1'b0);
                    m_inv = model_path(inv_in, m_pos, 1'b1);
                end
                m_carry = 1'b0;
                if (ld) begin
                    if (int'(ld_pos) <= 25) m_pos = int'(ld_pos);
                end else if (step) begin
                    m_carry = (m_pos == 21);
                    m_pos = (m_pos + 1) % 26;
                end
            end
            @(posedge clk); #1;
            check("rnd_pos", {21'd0, pos}, 26'(m_pos));
            check("rnd_carry", {25'd0, carry}, {25'd0, m_carry});
            check("rnd_valid", {25'd0, out_valid}, {25'd0, m_valid});
            check("rnd_fwd", fwd_out, m_fwd);
            check("rnd_inv", inv_out, m_inv);
        end
        idle_inputs();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
